cook_timer: RTL and testbench
=============================

Name: cook_timer

Overview:
Countdown timer feeding the magnetron control stage: produces `timer_done`, which ends cooking, and consumes `mag_on`, which gates counting.
- Holds cook time as 4 BCD digits, MM:SS, entered digit-by-digit from the keypad.
- Counts down one second per `TICKS_PER_SEC` clocks while `mag_on` is high.
- Flags zero time.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per counted second (benches use 4)
PRESC_W, 26, prescaler width; must satisfy 2**PRESC_W >= TICKS_PER_SEC

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
mag_on  input  1  magnetron-on level from control; enables countdown
clrn  input  1  active-low clear, sampled on clk
digit_valid  input  1  one-cycle keypad strobe
digit  input  4  BCD keypad digit, valid with digit_valid
time_bcd  output  16  {m10,m1,s10,s1} current time, registered
timer_done  output  1  high while time_bcd == 0, registered
done_pulse  output  1  one-cycle pulse when countdown reaches 0 (beeper)

Behaviour:
- Reset (rstn low, async):
  - time_bcd=16'h0000, timer_done=1, done_pulse=0, prescaler=0.
  - Leaving reset takes effect on the next clk edge.
- Priority per clock, highest first: clrn low > countdown step > digit entry.
- Clear (clrn low):
  - time_bcd<=0, prescaler<=0, timer_done<=1, done_pulse<=0.
  - Applies whatever mag_on is.
- Digit entry:
  - Accepted only when digit_valid=1, mag_on=0, clrn=1 and digit<=9.
  - Digits >9 are ignored with no state change.
  - Shift left: m10<=m1, m1<=s10, s10<=s1, s1<=digit.
  - The old m10 is discarded.
  - Any entered digit is legal in any position, so 00:99 counts as 99 s.
  - timer_done updates the cycle after entry.
- Prescaler:
  - Counts while mag_on=1 and time_bcd!=0.
  - On reaching TICKS_PER_SEC-1 it wraps to 0 and asserts an internal step for that cycle.
  - Holds its value while mag_on=0, so a paused partial second is preserved.
  - Cleared to 0 when time reaches 0.
- Countdown step (BCD decrement, registered):
  - if s1>0: s1--
  - else s1=9; if s10>0: s10--
  - else s10=5; if m1>0: m1--
  - else m1=9; m10--
- Stop at zero:
  - No step occurs at 00:00; time never wraps to 99:59.
  - Counting stops even if mag_on stays high.
- timer_done = (next time_bcd == 0), registered with time_bcd so both change on the same edge.
  - High at idle-zero, so control cannot start with zero time.
- done_pulse:
  - High for exactly one cycle when a countdown step moves time from 00:01 to 00:00.
  - Not asserted by clear, reset, or entry.
- mag_on dropping mid-second: time frozen, prescaler frozen; resumes on the next mag_on high.
- digit_valid while mag_on=1: ignored, no queuing.
- Latency:
  - First step occurs TICKS_PER_SEC clocks after mag_on rises with a zero prescaler.
  - time_bcd and timer_done update the edge after that.

Decomposition:
- Shared include header, `level3` style: BCD digit width, BCD zero constant, max seconds-tens value (5).
- Natural sub-module `sec_prescaler`:
  - Parameter TICKS_PER_SEC.
  - Inputs: clk, rstn, en, clr.
  - Output: step, a one-cycle pulse.
- BCD decrement and entry shift stay in `cook_timer`.

Test Plan (TICKS_PER_SEC=4):
1. Reset -> time_bcd=0000, timer_done=1, done_pulse=0. Then digits 1,3,0 with mag_on=0 -> time_bcd=16'h0130, timer_done=0. Digit 11 -> no change.
2. Load 0005, hold mag_on=1 -> time decrements every 4 clocks (0004…0000). done_pulse high exactly once, on the 0001->0000 edge. timer_done rises the same edge. Time stays 0000 with mag_on still high for 20 more clocks.
3. Load 0100, mag_on=1 for 4 clocks -> 0059. Load 1000 -> next step 0959. Load 0099 -> steps 0098, 0097.
4. Load 0010, mag_on=1 for 6 clocks, then 0 for 10 clocks -> time holds 0009. Digit entry during the pause is accepted. mag_on=1 with prescaler at 2 -> next step after 2 clocks.
5. mag_on=1 counting at 0130, pulse clrn low for 1 cycle -> next edge time_bcd=0000, timer_done=1, done_pulse=0. Digit strobe with mag_on=1 -> ignored.
6. rstn asserted mid-count at 0042 -> outputs immediately (async) 0000 / timer_done=1. Count restarts only after new entry.

Source files
------------

// File: rtl/cook_timer_pkg.sv
// Shared BCD definitions for the cook timer: digit width, time layout and
// the digit constants used by the countdown and keypad entry logic.
package cook_timer_pkg;

   localparam int BCD_W = 4;

   localparam logic [BCD_W-1:0] BCD_DIGIT_ZERO = 4'd0;
   localparam logic [BCD_W-1:0] BCD_DIGIT_ONE  = 4'd1;
   localparam logic [BCD_W-1:0] BCD_NINE       = 4'd9;
   localparam logic [BCD_W-1:0] SEC_TENS_MAX   = 4'd5;

   typedef struct packed {
      logic [BCD_W-1:0] m10;
      logic [BCD_W-1:0] m1;
      logic [BCD_W-1:0] s10;
      logic [BCD_W-1:0] s1;
   } bcd_time_t;

   localparam bcd_time_t BCD_ZERO = 16'h0000;
   localparam bcd_time_t BCD_ONE  = 16'h0001;

endpackage

// File: rtl/cook_timer_sec_prescaler.sv
// Divides clk down to a one-cycle step pulse every TICKS_PER_SEC enabled
// clocks; the partial count is held while en is low.
module cook_timer_sec_prescaler #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int PRESC_W       = 26
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic clr,
   output logic step
);

   logic [PRESC_W-1:0] r_cnt;
   logic               w_last;

   assign w_last = (r_cnt == PRESC_W'(TICKS_PER_SEC - 1));
   assign step   = en & w_last;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         if (w_last) r_cnt <= '0;
         else        r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cook_timer.sv
// MM:SS BCD cook timer: keypad digit entry while idle, one-second countdown
// while the magnetron is on, zero flag and end-of-cook beeper pulse.
module cook_timer
   import cook_timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int PRESC_W       = 26
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        mag_on,
   input  logic        clrn,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   output logic [15:0] time_bcd,
   output logic        timer_done,
   output logic        done_pulse
);

   bcd_time_t r_time;
   bcd_time_t w_time_nxt;
   logic      r_done;
   logic      r_pulse;
   logic      w_pulse_nxt;
   logic      w_time_nz;
   logic      w_presc_en;
   logic      w_presc_clr;
   logic      w_step;
   logic      w_entry;

   // Minutes digits borrow through 9, seconds tens through 5.
   function automatic bcd_time_t bcd_dec(input bcd_time_t t);
      bcd_time_t res;
      res = t;
      if (t.s1 != BCD_DIGIT_ZERO) begin
         res.s1 = t.s1 - BCD_DIGIT_ONE;
      end else begin
         res.s1 = BCD_NINE;
         if (t.s10 != BCD_DIGIT_ZERO) begin
            res.s10 = t.s10 - BCD_DIGIT_ONE;
         end else begin
            res.s10 = SEC_TENS_MAX;
            if (t.m1 != BCD_DIGIT_ZERO) begin
               res.m1 = t.m1 - BCD_DIGIT_ONE;
            end else begin
               res.m1  = BCD_NINE;
               res.m10 = t.m10 - BCD_DIGIT_ONE;
            end
         end
      end
      return res;
   endfunction

   assign w_time_nz   = (r_time != BCD_ZERO);
   assign w_presc_en  = mag_on & w_time_nz;
   assign w_presc_clr = ~clrn | ~w_time_nz;
   assign w_entry     = digit_valid & ~mag_on & (digit <= BCD_NINE);

   cook_timer_sec_prescaler #(
      .TICKS_PER_SEC (TICKS_PER_SEC),
      .PRESC_W       (PRESC_W)
   ) u_presc (
      .clk  (clk),
      .rstn (rstn),
      .en   (w_presc_en),
      .clr  (w_presc_clr),
      .step (w_step)
   );

   // Clear beats countdown beats entry; step and entry exclude each other via mag_on.
   always_comb begin
      w_time_nxt  = r_time;
      w_pulse_nxt = 1'b0;
      if (!clrn) begin
         w_time_nxt = BCD_ZERO;
      end else if (w_step) begin
         w_time_nxt  = bcd_dec(r_time);
         w_pulse_nxt = (r_time == BCD_ONE);
      end else if (w_entry) begin
         w_time_nxt = {r_time.m1, r_time.s10, r_time.s1, digit};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_time  <= BCD_ZERO;
         r_done  <= 1'b1;
         r_pulse <= 1'b0;
      end else begin
         r_time  <= w_time_nxt;
         r_done  <= (w_time_nxt == BCD_ZERO);
         r_pulse <= w_pulse_nxt;
      end
   end

   assign time_bcd   = r_time;
   assign timer_done = r_done;
   assign done_pulse = r_pulse;

endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer: directed scenarios plus a random phase, all checked
// against a decimal MMSS reference model.
module tb_cook_timer;

   localparam int TPS     = 4;
   localparam int PRESC_W = 3;

   logic        clk = 1'b0;
   logic        rstn;
   logic        mag_on;
   logic        clrn;
   logic        digit_valid;
   logic [3:0]  digit;
   logic [15:0] time_bcd;
   logic        timer_done;
   logic        done_pulse;

   int total = 0;
   int bad   = 0;

   // Reference state: time as a decimal number MMSS (0..9999).
   int m_val;
   int m_p;
   bit m_done;
   bit m_pulse;

   cook_timer #(
      .TICKS_PER_SEC (TPS),
      .PRESC_W       (PRESC_W)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .mag_on      (mag_on),
      .clrn        (clrn),
      .digit_valid (digit_valid),
      .digit       (digit),
      .time_bcd    (time_bcd),
      .timer_done  (timer_done),
      .done_pulse  (done_pulse)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'(v / 1000);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   // One second less, treating MM and SS as separate two-digit fields.
   function automatic int dec_val(input int v);
      int mn;
      int sc;
      mn = v / 100;
      sc = v % 100;
      if (sc > 0) sc = sc - 1;
      else begin
         sc = 59;
         mn = mn - 1;
      end
      return mn * 100 + sc;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_val   = 0;
      m_p     = 0;
      m_done  = 1'b1;
      m_pulse = 1'b0;
   endtask

   task automatic model_clock(input bit mg, input bit cl, input bit dv, input logic [3:0] dg);
      if (!cl) begin
         model_reset();
      end else begin
         m_pulse = 1'b0;
         if (mg && m_val != 0) begin
            if (m_p == TPS - 1) begin
               m_p = 0;
               if (m_val == 1) m_pulse = 1'b1;
               m_val = dec_val(m_val);
            end else begin
               m_p = m_p + 1;
            end
         end else begin
            if (m_val == 0) m_p = 0;
            if (!mg && dv && dg <= 4'd9) m_val = (m_val * 10 + int'(dg)) % 10000;
         end
         m_done = (m_val == 0);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".time"}, time_bcd, to_bcd(m_val));
      chk({tag, ".done"}, 16'(timer_done), 16'(m_done));
      chk({tag, ".pulse"}, 16'(done_pulse), 16'(m_pulse));
   endtask

   task automatic cycle(input string tag, input bit mg, input bit cl, input bit dv, input logic [3:0] dg);
      @(negedge clk);
      mag_on      = mg;
      clrn        = cl;
      digit_valid = dv;
      digit       = dg;
      @(posedge clk);
      model_clock(mg, cl, dv, dg);
      #1;
      check_all(tag);
   endtask

   task automatic enter(input logic [3:0] dg);
      cycle("enter", 1'b0, 1'b1, 1'b1, dg);
   endtask

   task automatic load4(input int v);
      cycle("clr", 1'b0, 1'b0, 1'b0, 4'd0);
      enter(4'(v / 1000));
      enter(4'((v / 100) % 10));
      enter(4'((v / 10) % 10));
      enter(4'(v % 10));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle("run", 1'b1, 1'b1, 1'b0, 4'd0);
   endtask

   task automatic pause(input int n);
      for (int i = 0; i < n; i++) cycle("pause", 1'b0, 1'b1, 1'b0, 4'd0);
   endtask

   initial begin
      int pulses;
      bit seg_mg;
      int seg_len;

      rstn        = 1'b0;
      mag_on      = 1'b0;
      clrn        = 1'b1;
      digit_valid = 1'b0;
      digit       = 4'd0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rstn = 1'b1;

      // 1: entry, invalid digit ignored
      enter(4'd1);
      enter(4'd3);
      enter(4'd0);
      chk("t1.val", time_bcd, 16'h0130);
      chk("t1.done", 16'(timer_done), 16'd0);
      enter(4'd11);
      chk("t1.ign", time_bcd, 16'h0130);

      // 2: countdown to zero, single pulse, stop at zero
      load4(5);
      pulses = 0;
      for (int i = 0; i < 5 * TPS; i++) begin
         cycle("t2", 1'b1, 1'b1, 1'b0, 4'd0);
         if (done_pulse) pulses++;
      end
      chk("t2.pulses", 16'(pulses), 16'd1);
      chk("t2.zero", time_bcd, 16'h0000);
      run(20);
      chk("t2.hold", time_bcd, 16'h0000);

      // 3: BCD borrows
      load4(100);
      run(TPS);
      chk("t3.0059", time_bcd, 16'h0059);
      load4(1000);
      run(TPS);
      chk("t3.0959", time_bcd, 16'h0959);
      load4(99);
      run(2 * TPS);
      chk("t3.0097", time_bcd, 16'h0097);

      // 4: pause preserves partial second, entry during pause
      load4(10);
      run(6);
      pause(10);
      chk("t4.hold", time_bcd, 16'h0009);
      enter(4'd3);
      chk("t4.entry", time_bcd, 16'h0093);
      run(2);
      chk("t4.resume", time_bcd, 16'h0092);

      // 5: clear while counting, digit ignored with mag_on
      load4(130);
      run(3);
      cycle("t5.clr", 1'b1, 1'b0, 1'b0, 4'd0);
      chk("t5.zero", time_bcd, 16'h0000);
      cycle("t5.ign", 1'b1, 1'b1, 1'b1, 4'd7);
      chk("t5.ignval", time_bcd, 16'h0000);

      // 6: async reset mid-count
      load4(42);
      run(2);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      check_all("t6.async");
      chk("t6.val", time_bcd, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      run(2 * TPS);
      chk("t6.idle", time_bcd, 16'h0000);
      enter(4'd2);
      run(TPS);
      chk("t6.restart", time_bcd, 16'h0001);

      // Random phase
      seg_mg  = 1'b0;
      seg_len = 0;
      for (int i = 0; i < 1500; i++) begin
         bit cl;
         bit dv;
         if (seg_len == 0) begin
            seg_mg  = ($urandom_range(0, 1) == 1);
            seg_len = $urandom_range(1, 24);
         end
         seg_len--;
         cl = ($urandom_range(0, 80) != 0);
         dv = seg_mg ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
         cycle("rnd", seg_mg, cl, dv, 4'($urandom_range(0, 15)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
